cnn_inference_scheduler: RTL

- Shares the single CIFAR-10 CNN accelerator between up to NUM_REQ requesters (AXI masters), one inference job at a time.
- Performs round-robin arbitration, issues the start pulse and image index, and waits for done or a watchdog timeout.
- Routes the predicted class back to the granted requester.
- Sits between the AXI-side requesters and the secure FSM/CNN start path; honours the security lock.

---
 rtl/cnn_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/cnn_inference_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cnn_sched_pkg.sv
// Shared types and constants for the CNN inference scheduler.
package cnn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Master ID width is fixed regardless of how many requesters are populated.
  localparam int MID_W = 2;

  // All-ones result reported when a job is aborted by the watchdog;
  // users slice it down to their class width.
  localparam logic [31:0] CLASS_ERR = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request found
// searching upward from i_ptr+1 (mod NUM_REQ) wins.
module rr_arbiter
  import cnn_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [MID_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [MID_W-1:0]   o_id
);

  logic             w_found;
  logic [MID_W-1:0] w_idx;

  // Walk the requesters in priority order and keep the first hit.
  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = MID_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/cnn_inference_scheduler.sv
// Shares one CNN accelerator between NUM_REQ requesters, one job at a time,
// with round-robin grants, a watchdog on the job, and a security lock that
// blocks new grants without disturbing the job in flight.
//
// Handshake: a requester holds req_valid until it sees its req_ready bit
// (only ever high in IDLE with the lock clear); the job is accepted on the
// clock edge where both are high. Results come back as a one-cycle
// rsp_valid strobe with no back-pressure.
module cnn_inference_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 5,
  parameter int CLASS_W     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_image_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     lock_in,
  output logic                     cnn_start,
  output logic [IDX_W-1:0]         cnn_image_idx,
  output logic [MID_W-1:0]         cnn_master_id,
  input  logic                     cnn_done,
  input  logic [CLASS_W-1:0]       cnn_class,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [CLASS_W-1:0]       rsp_class,
  output logic                     rsp_error,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t               r_state, w_state_nxt;
  logic [MID_W-1:0]     r_ptr;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [IDX_W-1:0]     r_idx;
  logic [MID_W-1:0]     r_mid;
  logic [CNT_W-1:0]     r_cnt;
  logic [CLASS_W-1:0]   r_class;
  logic                 r_err;

  logic [NUM_REQ-1:0]   w_gnt;
  logic [MID_W-1:0]     w_gnt_id;
  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_accept;
  logic                 w_timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_id  (w_gnt_id)
  );

  assign w_accept  = (r_state == ST_IDLE) && !lock_in && (|req_valid);
  assign w_timeout = (r_cnt == CNT_MAX);

  // Pick the granted requester's image index out of the packed bus.
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_id == MID_W'(i)) w_sel_idx = req_image_idx[i*IDX_W +: IDX_W];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and all state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    cnn_start   = 1'b0;
    rsp_valid   = '0;
    rsp_class   = '0;
    rsp_error   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (!lock_in) req_ready = w_gnt;
        if (w_accept) w_state_nxt = ST_START;
      end
      ST_START: begin
        cnn_start   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnn_done || w_timeout) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid   = r_gnt;
        rsp_class   = r_class;
        rsp_error   = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Job context: grant capture, watchdog counter, result capture, pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr   <= MID_W'(NUM_REQ - 1);
      r_gnt   <= '0;
      r_idx   <= '0;
      r_mid   <= '0;
      r_cnt   <= '0;
      r_class <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_gnt <= w_gnt;
            r_idx <= w_sel_idx;
            r_mid <= w_gnt_id;
          end
        end
        ST_START: r_cnt <= '0;
        ST_WAIT: begin
          // Done takes priority over a watchdog expiry in the same cycle.
          if (cnn_done) begin
            r_class <= cnn_class;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_class <= CLASS_ERR[CLASS_W-1:0];
            r_err   <= 1'b1;
          end
          if (!w_timeout) r_cnt <= r_cnt + 1'b1;
        end
        ST_RESP: r_ptr <= r_mid;
        default: ;
      endcase
    end
  end

  assign cnn_image_idx = r_idx;
  assign cnn_master_id = r_mid;
  assign dbg_state     = r_state;

endmodule
